serial_adder: RTL and testbench

- Bit-serial adder of two WIDTH-bit operands, one bit per clock, LSB first.
- Built around a single instance of the existing gate-level FullAdder, with a flip-flop holding the carry between bits.
- Sits directly upstream of FullAdder: it drives the FullAdder a/b/c inputs from operand shift registers each cycle, then collects its sum and carry outputs.
- First sequential arithmetic block in the datapath; trades latency for gate count against a ripple adder.

---
 rtl/serial_adder.sv | 72 +++++++
 tb/tb_serial_adder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder around a single full_adder with a carry flop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, fa_sum, fa_carry;
  full_adder u_fa (.a(sh_a[0]), .b(sh_b[0]), .c(carry), .s(fa_sum), .co(fa_carry));
  // shift form keeps WIDTH=1 legal: the new bit lands in the MSB
  assign acc_nxt = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign busy    = state == RUN;
  assign done    = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        sh_a  <= a;
        sh_b  <= b;
        carry <= cin;
        cnt   <= '0;
        acc   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= fa_carry;
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        sum   <= acc_nxt;
        cout  <= fa_carry;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table plus corner sequences and random back-to-back sweeps for WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  int passed = 0, total = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic [7:0] es, input logic ec);
    int n_busy = 0, n_early = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = xa; b8 = xb; cin8 = xc;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (busy8) n_busy++;
      if (done8) n_early++;
      @(negedge clk);
    end
    chk("busy_cycles", n_busy, 8);
    chk("early_done", n_early, 0);
    chk("done_pulse", done8, 1);
    chk("busy_in_done", busy8, 0);
    chk("sum", sum8, es);
    chk("cout", cout8, ec);
    @(negedge clk);
    chk("done_one_cycle", done8, 0);
  endtask

  task automatic b2b8(input int n);
    logic [7:0] qa = 8'($urandom), qb = 8'($urandom);
    logic       qc = 1'($urandom);
    int got = 0, last = -1, cyc = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = qa; b8 = qb; cin8 = qc;
    while (got < n && cyc < n * 12 + 20) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        chk("b2b8_result", {cout8, sum8}, 9'(qa) + 9'(qb) + 9'(qc));
        if (last >= 0) chk("b2b8_gap", cyc - last, 10);
        last = cyc;
        got++;
        qa = 8'($urandom); qb = 8'($urandom); qc = 1'($urandom);
        a8 = qa; b8 = qb; cin8 = qc;
      end
    end
    start8 = 1'b0;
    chk("b2b8_count", got, n);
  endtask

  task automatic b2b1(input int n);
    logic qa = 1'($urandom), qb = 1'($urandom), qc = 1'($urandom);
    int got = 0, last = -1, cyc = 0;
    @(negedge clk);
    start1 = 1'b1; a1 = qa; b1 = qb; cin1 = qc;
    while (got < n && cyc < n * 5 + 20) begin
      @(negedge clk);
      cyc++;
      if (done1) begin
        chk("b2b1_result", {cout1, sum1}, 2'(qa) + 2'(qb) + 2'(qc));
        if (last >= 0) chk("b2b1_gap", cyc - last, 3);
        last = cyc;
        got++;
        qa = 1'($urandom); qb = 1'($urandom); qc = 1'($urandom);
        a1 = qa; b1 = qb; cin1 = qc;
      end
    end
    start1 = 1'b0;
    chk("b2b1_count", got, n);
  endtask

  initial begin
    int n_done;
    logic held_ok;
    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    tbl[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; start1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 0);
      chk("rst_done_w1", done1, 0);
      chk("rst_sum_w1", {cout1, sum1}, 0);
    end
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;

    for (int i = 0; i < 7; i++) add8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);

    n_done = 0; held_ok = 1'b1;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (i == 3) start8 = 1'b0;
      if (busy8 && (sum8 !== 8'h01 || cout8 !== 1'b0)) held_ok = 1'b0;
      if (done8) n_done++;
      @(negedge clk);
    end
    chk("ign_held", held_ok, 1);
    chk("ign_dones", n_done, 1);
    chk("ign_sum", sum8, 8'h46);
    chk("ign_cout", cout8, 0);

    @(negedge clk);
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 0);
    n_done = 0;
    repeat (12) begin
      if (done8) n_done++;
      @(negedge clk);
    end
    chk("abort_no_done", n_done, 0);
    add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    b2b8(200);
    b2b1(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
